sr_drive_seq: RTL and testbench

- Clocked command sequencer that drives the s/r inputs of an SR latch (SRLatch) and observes its q/q_bar outputs.
- Converts valid/ready set, reset, toggle and hold requests into timed s or r pulses with non-overlap guard time.
- The s=r=1 illegal input is never generated.
- Confirms the latch state through synchronized feedback and returns one response per request.

---
 rtl/sr_drive_pkg.sv | 20 ++
 rtl/sr_sync.sv | 20 ++
 rtl/sr_drive_seq.sv | 146 ++++++++++++++
 tb/tb_sr_drive_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sr_drive_pkg.sv
// Shared definitions for the SR latch drive sequencer: op encodings, FSM states
// and the width of the optional error counter.
package sr_drive_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam int ERR_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GUARD,
    ST_PULSE,
    ST_WAIT_Q,
    ST_RESP
  } state_t;

endpackage

// File: rtl/sr_sync.sv
// Multi-flop synchronizer for one asynchronous latch output; clears to 0 on reset.
module sr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p <= '0;
    else        sync_p <= {sync_p[STAGES-2:0], din};
  end

  assign dout = sync_p[STAGES-1];

endmodule

// File: rtl/sr_drive_seq.sv
// Sequencer turning set/reset/toggle/hold requests into guarded s/r pulses for an
// SR latch and confirming q/q_bar. Optional error counter: SR_DRIVE_ERR_CNT_EN.
module sr_drive_seq
  import sr_drive_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int GUARD_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_err,
  output logic       resp_q,
  output logic       s,
  output logic       r,
  input  logic       q,
  input  logic       q_bar
`ifdef SR_DRIVE_ERR_CNT_EN
  ,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int CNT_PG  = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES : GUARD_CYCLES;
  localparam int CNT_MAX = (CNT_PG > TIMEOUT_CYCLES) ? CNT_PG : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_TOP      = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tgt, tgt_nxt;
  logic             err_nxt, q_nxt;
  logic             q_s, qb_s;

  sr_sync #(.STAGES(SYNC_STAGES)) u_sync_q  (.clk(clk), .rst_n(rst_n), .din(q),     .dout(q_s));
  sr_sync #(.STAGES(SYNC_STAGES)) u_sync_qb (.clk(clk), .rst_n(rst_n), .din(q_bar), .dout(qb_s));

  // s/r come straight from the next state, so only one of them can ever be set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      tgt        <= 1'b0;
      s          <= 1'b0;
      r          <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      tgt        <= tgt_nxt;
      s          <= (state_nxt == ST_PULSE) &&  tgt_nxt;
      r          <= (state_nxt == ST_PULSE) && !tgt_nxt;
      req_ready  <= (state_nxt == ST_IDLE);
      resp_valid <= (state_nxt == ST_RESP);
      resp_err   <= err_nxt;
      resp_q     <= q_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    err_nxt   = resp_err;
    q_nxt     = resp_q;
    cnt_nxt   = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (req_valid && req_ready) begin
          case (req_op)
            OP_SET:    tgt_nxt = 1'b1;
            OP_RESET:  tgt_nxt = 1'b0;
            OP_TOGGLE: tgt_nxt = ~q_s;
            default:   tgt_nxt = tgt;
          endcase
          if (req_op == OP_HOLD) begin
            state_nxt = ST_RESP;
            err_nxt   = 1'b0;
            q_nxt     = q_s;
          end else if (GUARD_CYCLES > 0) begin
            state_nxt = ST_GUARD;
          end else begin
            state_nxt = ST_PULSE;
          end
        end
      end
      ST_GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = '0;
        end
      end
      ST_PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_nxt = ST_WAIT_Q;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_Q: begin
        // Both rails must agree with the target; a stuck or split latch times out.
        if (q_s == tgt && qb_s == ~tgt) begin
          state_nxt = ST_RESP;
          err_nxt   = 1'b0;
          q_nxt     = q_s;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = ST_RESP;
          err_nxt   = 1'b1;
          q_nxt     = q_s;
          cnt_nxt   = '0;
        end
      end
      ST_RESP: begin
        cnt_nxt = '0;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef SR_DRIVE_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (resp_valid && resp_ready && resp_err && err_cnt != {ERR_CNT_W{1'b1}})
      err_cnt <= err_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_sr_drive_seq.sv
// Directed bench for sr_drive_seq driving a behavioural SR latch that can be stuck.
module tb_sr_drive_seq;
  import sr_drive_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = OP_HOLD;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic       resp_err;
  logic       resp_q;
  logic       s, r, q, q_bar;
`ifdef SR_DRIVE_ERR_CNT_EN
  logic       err_clr = 1'b0;
  logic [7:0] err_cnt;
`endif

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  stuck = 1'b0;
  logic lq = 1'b0;
  bit  overlap_seen = 1'b0;

  always #5 clk = ~clk;

  sr_drive_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_err(resp_err), .resp_q(resp_q),
    .s(s), .r(r), .q(q), .q_bar(q_bar)
`ifdef SR_DRIVE_ERR_CNT_EN
    , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
  );

  // Behavioural SR latch; stuck forces q=0, q_bar=1 regardless of drive.
  always @(s, r) begin
    if (s && !r)      lq = 1'b1;
    else if (r && !s) lq = 1'b0;
    if (s && r)       overlap_seen = 1'b1;
  end
  assign q     = stuck ? 1'b0 : lq;
  assign q_bar = stuck ? 1'b1 : ~lq;

  always @(posedge clk) assert (!(s && r)) else $error("s and r both high");

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "_vld_drop"}, resp_valid, 1'b0);
    chk({tag, "_rdy_back"}, req_ready, 1'b1);
  endtask

  task automatic run_op(input logic [1:0] op, input string tag, input bit exp_s,
                        input int exp_lat, input bit exp_err, input bit exp_q);
    int w;
    int lat;
    w = 0;
    while (!req_ready && w < 20) begin tick(); w++; end
    chk({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_op    = op;
    tick();
    req_valid = 1'b0;
    chk({tag, "_busy"}, req_ready, 1'b0);
    if (op == OP_HOLD) begin
      chk({tag, "_vld"}, resp_valid, 1'b1);
      chk({tag, "_sr"}, {s, r}, 2'b00);
    end else begin
      chk({tag, "_guard"}, {s, r}, 2'b00);
      tick();
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_pulse"}, {s, r}, {exp_s, ~exp_s});
        tick();
      end
      chk({tag, "_off"}, {s, r}, 2'b00);
      lat = 0;
      while (!resp_valid && lat < 40) begin tick(); lat++; end
      chk({tag, "_lat"}, lat, exp_lat);
    end
    chk({tag, "_err"}, resp_err, exp_err);
    chk({tag, "_q"}, resp_q, exp_q);
    handshake(tag);
  endtask

  initial begin
    int w;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sr", {s, r}, 2'b00);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_vld", resp_valid, 1'b0);
    chk("rst_err", resp_err, 1'b0);
    chk("rst_q", resp_q, 1'b0);
    #19 rst_n = 1'b1;
    tick();
    chk("rst_ready_rise", req_ready, 1'b1);

    run_op(OP_SET,    "set",    1'b1, 1,  1'b0, 1'b1);
    run_op(OP_RESET,  "reset",  1'b0, 1,  1'b0, 1'b0);
    run_op(OP_TOGGLE, "toggle", 1'b1, 1,  1'b0, 1'b1);
    run_op(OP_HOLD,   "hold",   1'b0, 0,  1'b0, 1'b1);

    stuck = 1'b1;
    tick(); tick(); tick();
    run_op(OP_SET, "stuck", 1'b1, 16, 1'b1, 1'b0);
`ifdef SR_DRIVE_ERR_CNT_EN
    chk("errcnt_inc", err_cnt, 8'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errcnt_clr", err_cnt, 8'd0);
`endif
    stuck = 1'b0;
    tick(); tick(); tick();

    // Backpressure: a HOLD response held for 10 cycles while a SET waits.
    req_valid = 1'b1;
    req_op    = OP_HOLD;
    tick();
    req_op = OP_SET;
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld", resp_valid, 1'b1);
      chk("bp_q", resp_q, 1'b1);
      chk("bp_err", resp_err, 1'b0);
      chk("bp_ready", req_ready, 1'b0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_idle_ready", req_ready, 1'b1);
    chk("bp_idle_vld", resp_valid, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("bp_accepted", req_ready, 1'b0);
    chk("bp_guard", {s, r}, 2'b00);
    tick();
    chk("bp_pulse", {s, r}, 2'b10);
    w = 0;
    while (!resp_valid && w < 40) begin tick(); w++; end
    chk("bp_resp", resp_valid, 1'b1);
    chk("bp_resp_q", resp_q, 1'b1);
    handshake("bp");

    // Reset while s is high.
    req_valid = 1'b1;
    req_op    = OP_SET;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_pulse_s", s, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sr", {s, r}, 2'b00);
    chk("mid_rst_ready", req_ready, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk("mid_rel_vld", resp_valid, 1'b0);
    chk("mid_rel_ready", req_ready, 1'b1);
    run_op(OP_RESET, "recover", 1'b0, 1, 1'b0, 1'b0);

    chk("no_overlap", overlap_seen, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
